modem_rx_packer: RTL and testbench

//  Receive-side neighbour of the Ethernet TX nibble serialiser. Accepts 4-bit nibbles from the modem,

---
 rtl/rx_pkg.sv | 42 ++++
 rtl/crc16_nibble.sv | 28 ++
 rtl/modem_rx_packer.sv | 220 ++++++++++++++++++++++
 tb/tb_modem_rx_packer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared constants for the modem receive packer: FSM state codes, framing
// nibbles, CRC constants, default geometry and a word-assembly helper.
package rx_pkg;

  // Default frame geometry in packet memory.
  localparam logic [14:0] DEF_START_WR_POS = 15'd256;
  localparam logic [14:0] DEF_MAX_WORDS    = 15'd760;
  localparam logic [2:0]  DEF_MIN_PREAMBLE = 3'd2;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HUNT  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAD   = 3'd3;
  localparam logic [2:0] ST_HDR   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  // Framing nibbles.
  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  // CRC-16-CCITT, non-reflected.
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Drop a nibble into its MSB-first slot; slot 0 starts a fresh word so the
  // unfilled low nibbles of a partial word are always zero.
  function automatic logic [15:0] place_nibble(input logic [15:0] word,
                                               input logic [1:0]  idx,
                                               input logic [3:0]  nib);
    logic [15:0] res;
    case (idx)
      2'd0:    res = {nib, 12'h000};
      2'd1:    res = {word[15:12], nib, 8'h00};
      2'd2:    res = {word[15:8], nib, 4'h0};
      2'd3:    res = {word[15:4], nib};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/crc16_nibble.sv
// Combinational CRC-16-CCITT update by one nibble (MSB first).
// Only present when RX_CRC_EN is defined.
`ifdef RX_CRC_EN
module crc16_nibble
  import rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [3:0]  nib,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Push the four message bits through the LFSR, most significant first.
  always_comb begin
    c = crc_in;
    for (int i = 3; i >= 0; i--) begin
      if ((c[15] ^ nib[i]) == 1'b1) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule
`endif

// File: rtl/modem_rx_packer.sv
// Receive-side nibble packer: hunts preamble/SFD, packs nibbles MSB-first
// into 16-bit words written from START_WR_POS+1, then writes the word count
// at START_WR_POS. Optional feature macro: RX_CRC_EN (CRC-16 frame check).
module modem_rx_packer
  import rx_pkg::*;
#(
  parameter logic [14:0] START_WR_POS = DEF_START_WR_POS,
  parameter logic [14:0] MAX_WORDS    = DEF_MAX_WORDS,
  parameter logic [2:0]  MIN_PREAMBLE = DEF_MIN_PREAMBLE
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  fromModem,
  input  logic        modemValid,
  output logic [15:0] toMemory,
  output logic [14:0] writeMemLoc,
  output logic        memWrEn,
  output logic        frameDone,
  output logic [14:0] frameLen,
  output logic        frameErr,
  output logic        busy
);

  logic [2:0]  state_r, state_n;
  logic [2:0]  pcnt_r, pcnt_n;
  logic [1:0]  idx_r, idx_n;
  logic [15:0] word_r, word_n;
  logic [14:0] wcnt_r, wcnt_n;
  logic [14:0] addr_r, addr_n;
  logic        ovf_r, ovf_n;
  logic [15:0] wr_data_n;
  logic [14:0] wr_addr_n;
  logic        wr_en_n;
  logic        done_n;
  logic [14:0] len_n;
  logic        err_n;
  logic        busy_n;

`ifdef RX_CRC_EN
  logic [15:0] crc_r, crc_n, crc_step;
  logic        part_r, part_n;

  crc16_nibble u_crc (
    .crc_in  (crc_r),
    .nib     (fromModem),
    .crc_out (crc_step)
  );
`endif

  // Next-state, datapath and output decode for the receive FSM.
  always_comb begin
    state_n   = state_r;
    pcnt_n    = pcnt_r;
    idx_n     = idx_r;
    word_n    = word_r;
    wcnt_n    = wcnt_r;
    addr_n    = addr_r;
    ovf_n     = ovf_r;
    wr_en_n   = 1'b0;
    wr_data_n = toMemory;
    wr_addr_n = writeMemLoc;
    done_n    = 1'b0;
    len_n     = frameLen;
    err_n     = frameErr;
`ifdef RX_CRC_EN
    crc_n     = crc_r;
    part_n    = part_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (modemValid && (fromModem == PREAMBLE_NIB)) begin
          state_n = ST_HUNT;
          pcnt_n  = 3'd1;
        end else begin
          pcnt_n  = 3'd0;
        end
      end
      ST_HUNT: begin
        if (!modemValid) begin
          state_n = ST_IDLE;
          pcnt_n  = 3'd0;
        end else if (fromModem == PREAMBLE_NIB) begin
          if (pcnt_r != 3'd7) begin
            pcnt_n = pcnt_r + 3'd1;
          end else begin
            pcnt_n = pcnt_r;
          end
        end else if ((fromModem == SFD_NIB) && (pcnt_r >= MIN_PREAMBLE)) begin
          state_n = ST_DATA;
          pcnt_n  = 3'd0;
          addr_n  = START_WR_POS + 15'd1;
          wcnt_n  = 15'd0;
          idx_n   = 2'd0;
          word_n  = 16'h0000;
          ovf_n   = 1'b0;
`ifdef RX_CRC_EN
          crc_n   = CRC_INIT;
          part_n  = 1'b0;
`endif
        end else begin
          state_n = ST_IDLE;
          pcnt_n  = 3'd0;
        end
      end
      ST_DATA: begin
        if (modemValid) begin
          word_n = place_nibble(word_r, idx_r, fromModem);
          idx_n  = idx_r + 2'd1;
`ifdef RX_CRC_EN
          crc_n  = crc_step;
`endif
          if (idx_r == 2'd3) begin
            if (wcnt_r == MAX_WORDS) begin
              ovf_n   = 1'b1;
              state_n = ST_DRAIN;
            end else begin
              wr_en_n   = 1'b1;
              wr_data_n = word_n;
              wr_addr_n = addr_r;
              addr_n    = addr_r + 15'd1;
              wcnt_n    = wcnt_r + 15'd1;
            end
          end else begin
            wr_en_n = 1'b0;
          end
        end else if (idx_r != 2'd0) begin
          state_n = ST_PAD;
`ifdef RX_CRC_EN
          part_n  = 1'b1;
`endif
        end else begin
          state_n = ST_HDR;
        end
      end
      ST_PAD: begin
        idx_n   = 2'd0;
        state_n = ST_HDR;
        if (wcnt_r == MAX_WORDS) begin
          ovf_n     = 1'b1;
        end else begin
          wr_en_n   = 1'b1;
          wr_data_n = word_r;
          wr_addr_n = addr_r;
          addr_n    = addr_r + 15'd1;
          wcnt_n    = wcnt_r + 15'd1;
        end
      end
      ST_DRAIN: begin
        if (modemValid) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_HDR;
        end
      end
      ST_HDR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = START_WR_POS;
        wr_data_n = {1'b0, wcnt_r};
        done_n    = 1'b1;
        len_n     = wcnt_r;
`ifdef RX_CRC_EN
        err_n     = ovf_r | (crc_r != 16'h0000) | part_r;
`else
        err_n     = ovf_r;
`endif
        state_n   = ST_IDLE;
        pcnt_n    = 3'd0;
      end
      default: begin
        state_n = ST_IDLE;
        pcnt_n  = 3'd0;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State and registered outputs; synchronous reset abandons any frame.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      pcnt_r      <= 3'd0;
      idx_r       <= 2'd0;
      word_r      <= 16'h0000;
      wcnt_r      <= 15'd0;
      addr_r      <= 15'd0;
      ovf_r       <= 1'b0;
      toMemory    <= 16'h0000;
      writeMemLoc <= 15'd0;
      memWrEn     <= 1'b0;
      frameDone   <= 1'b0;
      frameLen    <= 15'd0;
      frameErr    <= 1'b0;
      busy        <= 1'b0;
`ifdef RX_CRC_EN
      crc_r       <= CRC_INIT;
      part_r      <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      pcnt_r      <= pcnt_n;
      idx_r       <= idx_n;
      word_r      <= word_n;
      wcnt_r      <= wcnt_n;
      addr_r      <= addr_n;
      ovf_r       <= ovf_n;
      toMemory    <= wr_data_n;
      writeMemLoc <= wr_addr_n;
      memWrEn     <= wr_en_n;
      frameDone   <= done_n;
      frameLen    <= len_n;
      frameErr    <= err_n;
      busy        <= busy_n;
`ifdef RX_CRC_EN
      crc_r       <= crc_n;
      part_r      <= part_n;
`endif
    end
  end

endmodule

// File: tb/tb_modem_rx_packer.sv
// Randomised self-checking bench for modem_rx_packer. A frame-level model
// turns each payload nibble list into the expected word writes and header;
// a negedge monitor matches every write strobe and frameDone against it.
module tb_modem_rx_packer;

  localparam int START = 256;
  localparam int MAXW  = 760;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  fromModem;
  logic        modemValid;
  logic [15:0] toMemory;
  logic [14:0] writeMemLoc;
  logic        memWrEn;
  logic        frameDone;
  logic [14:0] frameLen;
  logic        frameErr;
  logic        busy;

  modem_rx_packer dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .fromModem   (fromModem),
    .modemValid  (modemValid),
    .toMemory    (toMemory),
    .writeMemLoc (writeMemLoc),
    .memWrEn     (memWrEn),
    .frameDone   (frameDone),
    .frameLen    (frameLen),
    .frameErr    (frameErr),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t        exp_wr[$];
  int         exp_hdr[$];   // bit 15 = err, bits 14:0 = length
  logic [3:0] pay[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_wr = 0;
  int         n_done = 0;

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // CRC-16-CCITT over a nibble stream, bit by bit, MSB first.
  function automatic int crc_of_pay();
    int c = 16'hFFFF;
    for (int i = 0; i < pay.size(); i++) begin
      for (int b = 3; b >= 0; b--) begin
        int fb = ((c >> 15) & 1) ^ ((pay[i] >> b) & 1);
        c = (c << 1) & 16'hFFFF;
        if (fb != 0) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Expected writes and header for the frame carried by pay.
  task automatic model_frame();
    int n = pay.size();
    int nw = (n + 3) / 4;
    int kept = (nw > MAXW) ? MAXW : nw;
    int err = (nw > MAXW) ? 1 : 0;
    wr_t w;
    for (int i = 0; i < kept; i++) begin
      int d = 0;
      for (int k = 0; k < 4; k++) begin
        int j = 4 * i + k;
        d = d * 16 + ((j < n) ? int'(pay[j]) : 0);
      end
      w.a = START + 1 + i;
      w.d = d;
      exp_wr.push_back(w);
    end
`ifdef RX_CRC_EN
    if ((n % 4) != 0 || crc_of_pay() != 0) err = 1;
`endif
    w.a = START;
    w.d = kept;
    exp_wr.push_back(w);
    exp_hdr.push_back((err << 15) | kept);
  endtask

  // Monitor: every strobe must be predicted, in order.
  always @(negedge CLK) begin
    wr_t e;
    int h;
    if (RST_N === 1'b1) begin
      if (memWrEn) begin
        n_wr++;
        check_val("wr_predicted", (exp_wr.size() != 0) ? 1 : 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check_val("wr_addr", int'(writeMemLoc), e.a);
          check_val("wr_data", int'(toMemory), e.d);
        end
      end
      if (frameDone) begin
        n_done++;
        check_val("done_with_wr", int'(memWrEn), 1);
        check_val("done_predicted", (exp_hdr.size() != 0) ? 1 : 0, 1);
        if (exp_hdr.size() != 0) begin
          h = exp_hdr.pop_front();
          check_val("frame_len", int'(frameLen), h & 16'h7FFF);
          check_val("frame_err", int'(frameErr), (h >> 15) & 1);
        end
      end
    end
  end

  task automatic drive_nib(input logic [3:0] n);
    @(negedge CLK);
    modemValid = 1'b1;
    fromModem  = n;
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) begin
      @(negedge CLK);
      modemValid = 1'b0;
      fromModem  = 4'($urandom);
    end
  endtask

  // Preamble, SFD, payload from pay, then end of frame and drain check.
  task automatic run_frame(input int npre);
    model_frame();
    for (int i = 0; i < npre; i++) drive_nib(4'h5);
    drive_nib(4'hD);
    for (int i = 0; i < pay.size(); i++) drive_nib(pay[i]);
    idle_cycles(8);
    check_val("wr_drained", exp_wr.size(), 0);
    check_val("hdr_drained", exp_hdr.size(), 0);
    check_val("busy_idle", int'(busy), 0);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(4'($urandom));
  endtask

  initial begin
    int wr0, done0;
    RST_N = 1'b0;
    modemValid = 1'b0;
    fromModem = 4'h0;
    repeat (3) @(negedge CLK);
    check_val("rst_wr", int'(memWrEn), 0);
    check_val("rst_done", int'(frameDone), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_len", int'(frameLen), 0);
    check_val("rst_err", int'(frameErr), 0);
    check_val("rst_data", int'(toMemory), 0);
    check_val("rst_loc", int'(writeMemLoc), 0);
    RST_N = 1'b1;
    idle_cycles(2);

    // Two full words.
    pay = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    run_frame(2);
    check_val("t1_len_held", int'(frameLen), 2);
`ifndef RX_CRC_EN
    check_val("t1_err_held", int'(frameErr), 0);
`endif

    // Partial word padded with zeros.
    pay = '{4'hF, 4'hE};
    run_frame(2);
    check_val("t2_len_held", int'(frameLen), 1);

    // Rejected preambles: short SFD and glitch.
    wr0 = n_wr;
    done0 = n_done;
    drive_nib(4'h5);
    drive_nib(4'hD);
    idle_cycles(4);
    drive_nib(4'h5);
    drive_nib(4'h5);
    drive_nib(4'h7);
    check_val("hunt_busy", int'(busy), 1);
    idle_cycles(5);
    check_val("reject_no_wr", n_wr - wr0, 0);
    check_val("reject_no_done", n_done - done0, 0);
    check_val("reject_busy", int'(busy), 0);

    // Empty frame.
    pay.delete();
    run_frame(3);

    // Exactly MAX_WORDS words: no overflow.
    rand_pay(4 * MAXW);
    run_frame(2);
    check_val("max_len", int'(frameLen), MAXW);

    // Overflow: MAX_WORDS+3 words.
    rand_pay(4 * (MAXW + 3));
    run_frame(4);
    check_val("ovf_len", int'(frameLen), MAXW);
    check_val("ovf_err", int'(frameErr), 1);

    // Reset after two data words; no header for the aborted frame.
    begin
      wr_t w;
      rand_pay(9);
      for (int i = 0; i < 2; i++) begin
        w.a = START + 1 + i;
        w.d = (int'(pay[4*i]) << 12) | (int'(pay[4*i+1]) << 8) |
              (int'(pay[4*i+2]) << 4) | int'(pay[4*i+3]);
        exp_wr.push_back(w);
      end
      drive_nib(4'h5);
      drive_nib(4'h5);
      drive_nib(4'hD);
      for (int i = 0; i < 9; i++) drive_nib(pay[i]);
      @(negedge CLK);
      RST_N = 1'b0;
      modemValid = 1'b0;
      repeat (2) @(negedge CLK);
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_wr", int'(memWrEn), 0);
      check_val("midrst_len", int'(frameLen), 0);
      check_val("midrst_pending", exp_wr.size(), 0);
      RST_N = 1'b1;
      idle_cycles(2);
      rand_pay(4);
      run_frame(2);
    end

`ifdef RX_CRC_EN
    // Good and corrupted FCS.
    begin
      int fcs;
      pay = '{4'h3, 4'h1, 4'h3, 4'h2};
      fcs = crc_of_pay();
      for (int s = 12; s >= 0; s -= 4) pay.push_back(4'((fcs >> s) & 15));
      check_val("fcs_residue", crc_of_pay(), 0);
      run_frame(2);
      check_val("crc_good_err", int'(frameErr), 0);
      pay[1] = pay[1] ^ 4'h4;
      run_frame(2);
      check_val("crc_bad_err", int'(frameErr), 1);
    end
`endif

    // Random frames.
    for (int f = 0; f < 25; f++) begin
      rand_pay($urandom_range(0, 40));
      run_frame($urandom_range(2, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
